fp32_sum_ctrl: RTL and testbench



---
 rtl/fp32_sum_pkg.sv | 16 +
 rtl/fp32_sum_tag_pipe.sv | 24 ++
 rtl/fp32_sum_ctrl.sv | 159 +++++++++++++++
 tb/tb_fp32_sum_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_sum_pkg.sv
// Shared constants and types for the FP32 group-summation controller.
package fp32_sum_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  // The adder can hold at most ADD_LATENCY live partials, so this width covers every legal latency.
  localparam int MAX_ADD_LATENCY = 16;
  localparam int LIVE_CNT_W      = $clog2(MAX_ADD_LATENCY + 1);

  typedef enum logic [1:0] {
    ACC,
    DRAIN,
    OUT
  } sum_state_e;

endpackage

// File: rtl/fp32_sum_tag_pipe.sv
// Tag shift register kept in step with the adder pipeline; a 1 at the tail
// marks that the value currently on add_result is a live partial sum.
module fp32_sum_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic tag_i,
  output logic tag_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], tag_i};
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fp32_sum_ctrl.sv
// Streaming FP32 group-summation controller driving an external pipelined adder.
// Define FP32_SUM_CNT_EN to add the per-group accepted-beat counter and out_count port.
module fp32_sum_ctrl
  import fp32_sum_pkg::*;
#(
  parameter int ADD_LATENCY = 3
`ifdef FP32_SUM_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FP32_SUM_CNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  sum_state_e            state_q, state_d;
  logic [31:0]           add_a_q, add_a_d;
  logic [31:0]           add_b_q, add_b_d;
  logic [31:0]           pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [31:0]           out_data_q, out_data_d;
  logic [LIVE_CNT_W-1:0] live_q, live_d;
  logic                  tag_d;
  logic                  tag_e;
  logic                  beat;

  assign beat = in_valid && (state_q == ACC);

  fp32_sum_tag_pipe #(
    .DEPTH(ADD_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .clr  (clr),
    .tag_i(tag_d),
    .tag_o(tag_e)
  );

  // live_q counts partials in flight plus the one parked in pend; a group is
  // finished when the last live value emerges with nothing left to pair it with.
  always_comb begin
    state_d    = state_q;
    add_a_d    = FP32_POS_ZERO;
    add_b_d    = FP32_POS_ZERO;
    tag_d      = 1'b0;
    live_d     = live_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    out_data_d = out_data_q;
    unique case (state_q)
      ACC: begin
        if (beat) begin
          add_a_d = in_data;
          add_b_d = tag_e ? add_result : FP32_POS_ZERO;
          tag_d   = 1'b1;
          if (!tag_e) begin
            live_d = live_q + 1'b1;
          end
          if (in_last) begin
            state_d = DRAIN;
          end
        end else if (tag_e) begin
          add_a_d = add_result;
          tag_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (tag_e) begin
          if (pend_vld_q) begin
            add_a_d    = pend_q;
            add_b_d    = add_result;
            tag_d      = 1'b1;
            pend_vld_d = 1'b0;
            live_d     = live_q - 1'b1;
          end else if (live_q == LIVE_CNT_W'(1)) begin
            out_data_d = add_result;
            state_d    = OUT;
          end else begin
            pend_d     = add_result;
            pend_vld_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          live_d     = '0;
          pend_d     = FP32_POS_ZERO;
          pend_vld_d = 1'b0;
          state_d    = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ACC;
      add_a_q    <= FP32_POS_ZERO;
      add_b_q    <= FP32_POS_ZERO;
      pend_q     <= FP32_POS_ZERO;
      pend_vld_q <= 1'b0;
      out_data_q <= FP32_POS_ZERO;
      live_q     <= '0;
    end else begin
      state_q    <= state_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_data_q <= out_data_d;
      live_q     <= live_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;

`ifdef FP32_SUM_CNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Saturate rather than wrap so an oversized group never reports a small count.
  always_comb begin
    count_d = count_q;
    if ((state_q == OUT) && out_ready) begin
      count_d = '0;
    end else if (beat && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_fp32_sum_ctrl.sv
// Directed bench for fp32_sum_ctrl with a behavioural pipelined FP32 adder.
// Build with FP32_SUM_CNT_EN defined to also check out_count.
module tb_fp32_sum_ctrl;

  localparam int LAT  = 3;
  localparam int NVEC = 9;

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][31:0] data;
    logic             gap;
    logic [3:0]       hold;
    logic [31:0]      expSum;
    logic [7:0]       expCycle;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] inData;
  logic        inValid;
  logic        inLast;
  logic        inReady;
  logic [31:0] addA;
  logic [31:0] addB;
  logic [31:0] addResult;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
`ifdef FP32_SUM_CNT_EN
  logic [15:0] outCount;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  int startCycle  = 0;

  vec_t vecs [NVEC];
  vec_t drainVec;
  vec_t postVec;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  fp32_sum_ctrl #(
    .ADD_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_last   (inLast),
    .in_ready  (inReady),
    .add_a     (addA),
    .add_b     (addB),
    .add_result(addResult),
    .out_data  (outData),
    .out_valid (outValid),
    .out_ready (outReady)
`ifdef FP32_SUM_CNT_EN
    ,
    .out_count (outCount)
`endif
  );

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] b;
    logic [10:0] e64;
    if (x[30:23] == 8'h00) begin
      b = {x[31], 63'b0};
    end else begin
      if (x[30:23] == 8'hFF) e64 = 11'h7FF;
      else e64 = {3'b000, x[30:23]} + 11'd896;
      b = {x[31], e64, x[22:0], 29'b0};
    end
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e64;
    b   = $realtobits(r);
    e64 = b[62:52];
    if (e64 == 11'h000) return {b[63], 31'b0};
    if (e64 == 11'h7FF) return {b[63], 8'hFF, b[51:29] | {22'b0, (b[51:0] != 52'b0)}};
    return {b[63], 8'(e64 - 11'd896), b[51:29]};
  endfunction

  // The controller's operand register is the first of the LAT stages, so the
  // adder proper contributes the remaining LAT-1 stages.
  logic [31:0] addPipe [LAT-1];
  always @(posedge clk) begin
    addPipe[0] <= r2f(f2r(addA) + f2r(addB));
    for (int i = 1; i < LAT - 1; i++) addPipe[i] <= addPipe[i-1];
  end
  assign addResult = addPipe[LAT-2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the last beat.
  task automatic applyStimulus(input vec_t v, input string name);
    checkOutput({name, "_ready_at_start"}, 32'(inReady), 32'd1);
    startCycle = cycleCount;
    for (int i = 0; i < int'(v.n); i++) begin
      inValid = 1'b1;
      inData  = v.data[i];
      inLast  = (i == int'(v.n) - 1);
      @(posedge clk); #1;
      if (v.gap && (i != int'(v.n) - 1)) begin
        inValid = 1'b0;
        inLast  = 1'b0;
        @(posedge clk); #1;
      end
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    checkOutput({name, "_ready_drop"}, 32'(inReady), 32'd0);
  endtask

  task automatic awaitResult(input vec_t v, input string name);
    int waited = 0;
    while (!outValid && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!outValid) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_timeout: out_valid %0b after %0d cycles, required 1", name, outValid, waited);
    end else begin
      if (v.expCycle != 8'd0)
        checkOutput({name, "_latency"}, 32'(cycleCount - startCycle), 32'(v.expCycle));
      checkOutput({name, "_sum"}, outData, v.expSum);
      checkOutput({name, "_ready_busy"}, 32'(inReady), 32'd0);
`ifdef FP32_SUM_CNT_EN
      checkOutput({name, "_count"}, 32'(outCount), 32'(v.n));
`endif
      for (int h = 0; h < int'(v.hold); h++) begin
        @(posedge clk); #1;
        checkOutput({name, "_hold_valid"}, 32'(outValid), 32'd1);
        checkOutput({name, "_hold_data"}, outData, v.expSum);
        checkOutput({name, "_hold_ready"}, 32'(inReady), 32'd0);
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      checkOutput({name, "_valid_drop"}, 32'(outValid), 32'd0);
      checkOutput({name, "_ready_back"}, 32'(inReady), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr      = 1'b1;
    inData   = 32'h0;
    inValid  = 1'b0;
    inLast   = 1'b0;
    outReady = 1'b0;

    vecs[0] = '{n: 4'd1, data: {224'h0, 32'h3F800000}, gap: 1'b0, hold: 4'd0,
                expSum: 32'h3F800000, expCycle: 8'd4};
    vecs[1] = '{n: 4'd3, data: {160'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, gap: 1'b0,
                hold: 4'd4, expSum: 32'h40C00000, expCycle: 8'd11};
    vecs[2] = '{n: 4'd5, data: {96'h0, {5{32'h3F800000}}}, gap: 1'b1, hold: 4'd0,
                expSum: 32'h40A00000, expCycle: 8'd17};
    vecs[3] = '{n: 4'd4, data: {128'h0, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},
                gap: 1'b0, hold: 4'd0, expSum: 32'h41200000, expCycle: 8'd12};
    vecs[4] = '{n: 4'd1, data: {224'h0, 32'h80000000}, gap: 1'b0, hold: 4'd0,
                expSum: 32'h00000000, expCycle: 8'd4};
    vecs[5] = '{n: 4'd3, data: 256'h0, gap: 1'b0, hold: 4'd0,
                expSum: 32'h00000000, expCycle: 8'd11};
    vecs[6] = '{n: 4'd2, data: {192'h0, 32'hBF000000, 32'h3FC00000}, gap: 1'b0, hold: 4'd0,
                expSum: 32'h3F800000, expCycle: 8'd8};
    vecs[7] = '{n: 4'd2, data: {192'h0, 32'h7F800000, 32'h3F800000}, gap: 1'b0, hold: 4'd1,
                expSum: 32'h7F800000, expCycle: 8'd8};
    vecs[8] = '{n: 4'd7, data: {32'h0, {7{32'h3F000000}}}, gap: 1'b0, hold: 4'd0,
                expSum: 32'h40600000, expCycle: 8'd0};
    drainVec = '{n: 4'd3, data: {160'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, gap: 1'b0,
                 hold: 4'd0, expSum: 32'h40C00000, expCycle: 8'd11};
    postVec  = '{n: 4'd2, data: {192'h0, 32'h40000000, 32'h40000000}, gap: 1'b0, hold: 4'd0,
                 expSum: 32'h40800000, expCycle: 8'd8};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_data", outData, 32'h0);
    checkOutput("reset_add_a", addA, 32'h0);
    checkOutput("reset_add_b", addB, 32'h0);
`ifdef FP32_SUM_CNT_EN
    checkOutput("reset_out_count", 32'(outCount), 32'd0);
`endif
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      awaitResult(vecs[i], $sformatf("vec%0d", i));
    end

    // Two cycles into DRAIN the first pairwise add is on the adder inputs.
    applyStimulus(drainVec, "drain");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_in_ready", 32'(inReady), 32'd0);
    checkOutput("drain_add_a_live", 32'(addA != 32'h0), 32'd1);
    clr = 1'b1;
    #1;
    checkOutput("clr_out_valid", 32'(outValid), 32'd0);
    checkOutput("clr_in_ready", 32'(inReady), 32'd1);
    checkOutput("clr_add_a", addA, 32'h0);
    checkOutput("clr_add_b", addB, 32'h0);
    checkOutput("clr_out_data", outData, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    applyStimulus(postVec, "post_clr");
    awaitResult(postVec, "post_clr");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
